rv32i_encoder: RTL

//  Pipelined RV32I instruction encoder: packs field tuples (format, opcode, regs, funct, immediate) into 32-bit words.
//  It is the inverse of the instruction decoder. It feeds instruction-memory preload, self-test generation and the

---
 rtl/rv32i_encoder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/rv32i_encoder.sv
`default_nettype none
// ============================================================================
// rv32i_encoder : two-stage valid/ready RV32I encoder that packs field tuples into 32-bit words
// Revision      : 1.0
// ============================================================================
module rv32i_encoder #(
  parameter int COUNT_W      = 16,
  parameter bit NOP_ON_ERROR = 1'b1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [2:0]         fmt_i,
  input  logic [6:0]         opcode_i,
  input  logic [4:0]         rd_i,
  input  logic [2:0]         funct3_i,
  input  logic [4:0]         rs1_i,
  input  logic [4:0]         rs2_i,
  input  logic [6:0]         funct7_i,
  input  logic [31:0]        imm_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [31:0]        instruction_o,
  output logic               error_o,
  output logic [COUNT_W-1:0] count_o
);

  localparam logic [2:0]  FMT_R    = 3'd0;
  localparam logic [2:0]  FMT_I    = 3'd1;
  localparam logic [2:0]  FMT_S    = 3'd2;
  localparam logic [2:0]  FMT_B    = 3'd3;
  localparam logic [2:0]  FMT_U    = 3'd4;
  localparam logic [2:0]  FMT_J    = 3'd5;
  localparam logic [31:0] ERR_WORD = NOP_ON_ERROR ? 32'h0000_0013 : 32'h0000_0000;

  logic        s1_valid;
  logic        s1_err;
  logic [2:0]  s1_fmt;
  logic [6:0]  s1_opcode;
  logic [4:0]  s1_rd;
  logic [2:0]  s1_funct3;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [6:0]  s1_funct7;
  logic [31:0] s1_imm;

  logic        s2_adv;
  logic        s1_load;
  logic        accept;
  logic        in_err;
  logic signed [31:0] imm_s;
  logic [31:0] packed_word;

  // A stage loads when empty or when its current contents move on this cycle.
  assign s2_adv     = !out_valid_o || out_ready_i;
  assign s1_load    = !s1_valid || s2_adv;
  assign in_ready_o = !reset_i && s1_load;
  assign accept     = in_valid_i && in_ready_o;
  assign imm_s      = signed'(imm_i);

  always_comb begin
    in_err = (opcode_i[1:0] != 2'b11);
    case (fmt_i)
      FMT_R: ;
      FMT_I, FMT_S: begin
        if (imm_s < -2048 || imm_s > 2047) in_err = 1'b1;
      end
      FMT_B: begin
        if (imm_s < -4096 || imm_s > 4094 || imm_i[0]) in_err = 1'b1;
      end
      FMT_U: begin
        if (imm_i[11:0] != 12'd0) in_err = 1'b1;
      end
      FMT_J: begin
        if (imm_s < -1048576 || imm_s > 1048574 || imm_i[0]) in_err = 1'b1;
      end
      default: in_err = 1'b1;
    endcase
  end

  always_comb begin
    packed_word = 32'd0;
    case (s1_fmt)
      FMT_R: packed_word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
      FMT_I: packed_word = {s1_imm[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
      FMT_S: packed_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_funct3, s1_imm[4:0], s1_opcode};
      FMT_B: packed_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_funct3,
                            s1_imm[4:1], s1_imm[11], s1_opcode};
      FMT_U: packed_word = {s1_imm[31:12], s1_rd, s1_opcode};
      FMT_J: packed_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                            s1_rd, s1_opcode};
      default: packed_word = 32'd0;
    endcase
    if (s1_err) packed_word = ERR_WORD;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid      <= 1'b0;
      out_valid_o   <= 1'b0;
      instruction_o <= 32'd0;
      error_o       <= 1'b0;
      count_o       <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= accept;
        if (accept) begin
          s1_err    <= in_err;
          s1_fmt    <= fmt_i;
          s1_opcode <= opcode_i;
          s1_rd     <= rd_i;
          s1_funct3 <= funct3_i;
          s1_rs1    <= rs1_i;
          s1_rs2    <= rs2_i;
          s1_funct7 <= funct7_i;
          s1_imm    <= imm_i;
        end
      end
      // Payload only changes when new data arrives, so a drained stage keeps its last word.
      if (s2_adv) begin
        out_valid_o <= s1_valid;
        if (s1_valid) begin
          instruction_o <= packed_word;
          error_o       <= s1_err;
        end
      end
      if (out_valid_o && out_ready_i) count_o <= count_o + COUNT_W'(1);
    end
  end

endmodule
`default_nettype wire
